// File: rtl/id_inst_queue.sv
// id_inst_queue: IF->ID FIFO of {exc,pc,inst}; in_* push from IF, out_* head to decoder, count/full/empty/almost_full status, sticky ovf_err
module id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W = 32,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       br_kill,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [EXC_W-1:0]           in_exc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [EXC_W-1:0]           out_exc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       ovf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [EXC_W-1:0] exc_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign almost_full = count >= AF_CNT;
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_exc = out_valid ? exc_mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (push && !rst && !flush && !br_kill) begin
      pc_mem[wr_ptr] <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
      exc_mem[wr_ptr] <= in_exc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf_err <= 1'b0;
    end else if (br_kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (in_valid && !in_ready) ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: directed vector table plus wrap and mid-stream reset sequences for id_inst_queue
module tb_id_inst_queue;
  logic clk = 1'b0;
  logic rst, flush, br_kill, in_valid, out_ready;
  logic [31:0] in_pc, in_inst, in_exc;
  logic in_ready, out_valid, full, empty, almost_full, ovf_err;
  logic [31:0] out_pc, out_inst, out_exc;
  logic [2:0] count;
  int n_chk = 0;
  int n_fail = 0;
  id_inst_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .br_kill(br_kill),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_exc(out_exc), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] ctl;
    logic [31:0] pc, inst, exc, epc, einst, eexc;
    logic [2:0] ecnt;
    logic [5:0] eflg;
  } vec_t;
  vec_t tbl [24];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step(input logic [4:0] ctl, input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exc);
    {rst, flush, br_kill, in_valid, out_ready} = ctl;
    in_pc = pc;
    in_inst = inst;
    in_exc = exc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] einst, input logic [31:0] eexc, input logic [2:0] ecnt, input logic [5:0] eflg);
    chk({tag, " pc"}, out_pc, epc);
    chk({tag, " inst"}, out_inst, einst);
    chk({tag, " exc"}, out_exc, eexc);
    chk({tag, " count"}, 32'(count), 32'(ecnt));
    chk({tag, " flags"}, 32'({out_valid, full, empty, almost_full, in_ready, ovf_err}), 32'(eflg));
  endtask
  initial begin
    tbl[0]  = '{5'b10000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001010};
    tbl[1]  = '{5'b00011, 32'hBFC00000, 32'h24010001, 32'h0, 32'hBFC00000, 32'h24010001, 32'h0, 3'd1, 6'b100010};
    tbl[2]  = '{5'b00001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001010};
    tbl[3]  = '{5'b00010, 32'h100, 32'h11, 32'h0, 32'h100, 32'h11, 32'h0, 3'd1, 6'b100010};
    tbl[4]  = '{5'b00010, 32'h104, 32'h22, 32'h0, 32'h100, 32'h11, 32'h0, 3'd2, 6'b100010};
    tbl[5]  = '{5'b00010, 32'h108, 32'h33, 32'h10, 32'h100, 32'h11, 32'h0, 3'd3, 6'b100110};
    tbl[6]  = '{5'b00010, 32'h10C, 32'h44, 32'h0, 32'h100, 32'h11, 32'h0, 3'd4, 6'b110100};
    tbl[7]  = '{5'b00010, 32'h110, 32'h55, 32'h0, 32'h100, 32'h11, 32'h0, 3'd4, 6'b110101};
    tbl[8]  = '{5'b00011, 32'h110, 32'h55, 32'h0, 32'h104, 32'h22, 32'h0, 3'd3, 6'b100111};
    tbl[9]  = '{5'b00001, 32'h0, 32'h0, 32'h0, 32'h108, 32'h33, 32'h10, 3'd2, 6'b100011};
    tbl[10] = '{5'b00001, 32'h0, 32'h0, 32'h0, 32'h10C, 32'h44, 32'h0, 3'd1, 6'b100011};
    tbl[11] = '{5'b00001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001011};
    tbl[12] = '{5'b00010, 32'h200, 32'h66, 32'h20, 32'h200, 32'h66, 32'h20, 3'd1, 6'b100011};
    tbl[13] = '{5'b00010, 32'h204, 32'h67, 32'h0, 32'h200, 32'h66, 32'h20, 3'd2, 6'b100011};
    tbl[14] = '{5'b01011, 32'h208, 32'h68, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001010};
    tbl[15] = '{5'b00010, 32'h300, 32'h77, 32'h0, 32'h300, 32'h77, 32'h0, 3'd1, 6'b100010};
    tbl[16] = '{5'b00010, 32'h304, 32'h88, 32'h0, 32'h300, 32'h77, 32'h0, 3'd2, 6'b100010};
    tbl[17] = '{5'b00010, 32'h308, 32'h99, 32'h0, 32'h300, 32'h77, 32'h0, 3'd3, 6'b100110};
    tbl[18] = '{5'b00010, 32'h30C, 32'hAA, 32'h0, 32'h300, 32'h77, 32'h0, 3'd4, 6'b110100};
    tbl[19] = '{5'b00010, 32'h310, 32'hBB, 32'h0, 32'h300, 32'h77, 32'h0, 3'd4, 6'b110101};
    tbl[20] = '{5'b00001, 32'h0, 32'h0, 32'h0, 32'h304, 32'h88, 32'h0, 3'd3, 6'b100111};
    tbl[21] = '{5'b00111, 32'h314, 32'hCC, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001011};
    tbl[22] = '{5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001011};
    tbl[23] = '{5'b01000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'b001010};
    {rst, flush, br_kill, in_valid, out_ready} = 5'b10000;
    in_pc = '0;
    in_inst = '0;
    in_exc = '0;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].ctl, tbl[i].pc, tbl[i].inst, tbl[i].exc);
      chk_state($sformatf("vec%0d", i), tbl[i].epc, tbl[i].einst, tbl[i].eexc, tbl[i].ecnt, tbl[i].eflg);
      @(negedge clk);
    end
    step(5'b00011, 32'h400, 32'h400, 32'h0);
    chk_state("wrap0", 32'h400, 32'h400, 32'h0, 3'd1, 6'b100010);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      step(5'b00011, 32'h400 + 32'(4 * i), 32'h400 + 32'(4 * i), 32'h0);
      chk_state($sformatf("wrap%0d", i), 32'h400 + 32'(4 * i), 32'h400 + 32'(4 * i), 32'h0, 3'd1, 6'b100010);
    end
    @(negedge clk);
    step(5'b00001, 32'h0, 32'h0, 32'h0);
    chk_state("drain", 32'h0, 32'h0, 32'h0, 3'd0, 6'b001010);
    @(negedge clk);
    step(5'b00010, 32'h500, 32'h51, 32'h3);
    @(negedge clk);
    step(5'b00010, 32'h504, 32'h52, 32'h0);
    chk_state("pre_rst", 32'h500, 32'h51, 32'h3, 3'd2, 6'b100010);
    @(negedge clk);
    step(5'b10010, 32'h508, 32'h53, 32'h0);
    chk_state("mid_rst", 32'h0, 32'h0, 32'h0, 3'd0, 6'b001010);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
